// File: rtl/mem_port_arbiter.sv
// Arbitrates the CPU fetch and data ports onto one memory port. Data wins by
// default; a streak counter forces a fetch grant after MAX_D_STREAK data grants.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_address,
  input  logic        imem_read,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_enable,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  // Handshake: requesters hold read/write until their one-cycle resp; the
  // memory side sees strobes held stable until its one-cycle mem_resp.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

  state_t      state;
  state_t      state_next;
  logic [3:0]  streak;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        write_q;
  logic [31:0] irdata_q;
  logic [31:0] drdata_q;
  logic        d_req;
  logic        i_req;
  logic        grant_d;
  logic        grant_i;

  assign d_req   = dmem_read | dmem_write;
  assign i_req   = imem_read;
  assign grant_d = d_req && (!i_req || (streak < STREAK_LIMIT));
  assign grant_i = i_req && !grant_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I:  if (mem_resp) state_next = RESP_I;
      BUSY_D:  if (mem_resp) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured at grant so later requester changes are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak   <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      write_q  <= 1'b0;
      irdata_q <= 32'd0;
      drdata_q <= 32'd0;
    end else begin
      if (state == IDLE) begin
        if (grant_d) begin
          addr_q  <= dmem_address;
          wdata_q <= dmem_wdata;
          be_q    <= dmem_write ? dmem_byte_enable : 4'hF;
          write_q <= dmem_write;
          if (i_req) streak <= (streak == 4'hF) ? 4'hF : streak + 4'd1;
          else       streak <= 4'd0;
        end else if (grant_i) begin
          addr_q  <= imem_address;
          be_q    <= 4'hF;
          write_q <= 1'b0;
          streak  <= 4'd0;
        end
      end
      if (state == BUSY_I && mem_resp) irdata_q <= mem_rdata;
      if (state == BUSY_D && mem_resp) drdata_q <= mem_rdata;
    end
  end

  always_comb begin
    mem_read        = (state == BUSY_I) || ((state == BUSY_D) && !write_q);
    mem_write       = (state == BUSY_D) && write_q;
    mem_address     = addr_q;
    mem_wdata       = wdata_q;
    mem_byte_enable = be_q;
    imem_resp       = (state == RESP_I);
    dmem_resp       = (state == RESP_D);
    imem_rdata      = irdata_q;
    dmem_rdata      = drdata_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for single transactions
// plus hand-written sequences for starvation, reset abort and stray responses.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        i_rd;
    logic [31:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_iresp;
    logic [31:0] e_irdata;
    logic        e_dresp;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_read        = 1'b0;
    imem_address     = 32'd0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = 32'd0;
    dmem_wdata       = 32'd0;
    dmem_byte_enable = 4'd0;
    mem_resp         = 1'b0;
    mem_rdata        = 32'd0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_read"},  32'(mem_read), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_addr"},  mem_address, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_be"},    32'(mem_byte_enable), 32'd0);
    check({tag, "_iresp"},     32'(imem_resp), 32'd0);
    check({tag, "_irdata"},    imem_rdata, 32'd0);
    check({tag, "_dresp"},     32'(dmem_resp), 32'd0);
    check({tag, "_drdata"},    dmem_rdata, 32'd0);
    check({tag, "_state"},     32'(dut.state), 32'd0);
  endtask

  initial begin
    int   grants;
    logic prev_strobe;
    logic strobe;

    rst = 1'b1;
    idle_inputs();

    //               i_rd i_addr     d_rd d_wr d_addr      d_wdata       d_be   m_resp m_rdata        e_rd e_wr e_addr      e_wdata       e_be   e_iresp e_irdata      e_dresp e_drdata
    vecs[0]  = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h60,  32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h60,  32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h60,  32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h60,  32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h13,       1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h13,       1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h13,       1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h13,       1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h64, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b0, 32'h13,       1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h64, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h13,       1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h64, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h13,       1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h64, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h64,  32'h0,        4'hF, 1'b0, 32'h13,       1'b0, 32'h0};
    vecs[11] = '{1'b1, 32'h64, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h00100093, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h00100093, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'h12345678, 4'hC, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200, 32'h12345678, 4'hC, 1'b0, 32'h00100093, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h200, 32'h12345678, 4'hC, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b1, 32'h0};
    vecs[15] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h300, 32'h0,        4'h1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h300, 32'h0,        4'hF, 1'b0, 32'h00100093, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h300, 32'h0,        4'h1, 1'b1, 32'hA5A50001, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b1, 32'hA5A50001};
    vecs[18] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b0, 32'hA5A50001};
    vecs[19] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b0, 32'hA5A50001};
    vecs[20] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00100093, 1'b0, 32'hA5A50001};

    step();
    step();
    check_zero("reset");
    check("reset_streak", 32'(dut.streak), 32'd0);
    rst = 1'b0;

    // Each row: drive inputs, take one edge, compare. Address/byte-enable are
    // compared only while a strobe is expected, write data only for writes.
    for (int i = 0; i < 21; i++) begin
      imem_read        = vecs[i].i_rd;
      imem_address     = vecs[i].i_addr;
      dmem_read        = vecs[i].d_rd;
      dmem_write       = vecs[i].d_wr;
      dmem_address     = vecs[i].d_addr;
      dmem_wdata       = vecs[i].d_wdata;
      dmem_byte_enable = vecs[i].d_be;
      mem_resp         = vecs[i].m_resp;
      mem_rdata        = vecs[i].m_rdata;
      step();
      check($sformatf("v%0d_mem_read", i),  32'(mem_read),  32'(vecs[i].e_rd));
      check($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(vecs[i].e_wr));
      if (vecs[i].e_rd || vecs[i].e_wr) begin
        check($sformatf("v%0d_mem_addr", i), mem_address, vecs[i].e_addr);
        check($sformatf("v%0d_mem_be", i),   32'(mem_byte_enable), 32'(vecs[i].e_be));
      end
      if (vecs[i].e_wr)
        check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_iresp", i),  32'(imem_resp), 32'(vecs[i].e_iresp));
      check($sformatf("v%0d_irdata", i), imem_rdata, vecs[i].e_irdata);
      check($sformatf("v%0d_dresp", i),  32'(dmem_resp), 32'(vecs[i].e_dresp));
      check($sformatf("v%0d_drdata", i), dmem_rdata, vecs[i].e_drdata);
    end

    // Starvation: data reads and a fetch held continuously; the memory answers
    // one cycle after each strobe rises. Grants are identified by address.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(32'h400);
      exp_q.push_back(32'h80);
    end
    idle_inputs();
    dmem_read    = 1'b1;
    dmem_address = 32'h400;
    imem_read    = 1'b1;
    imem_address = 32'h80;
    grants       = 0;
    prev_strobe  = 1'b0;
    for (int c = 0; c < 200 && grants < 10; c++) begin
      step();
      strobe = mem_read | mem_write;
      if (strobe && !prev_strobe) begin
        grants++;
        if (exp_q.size() == 0) check("starve_extra_grant", mem_address, 32'hFFFFFFFF);
        else                   check($sformatf("starve_grant%0d", grants), mem_address, exp_q.pop_front());
      end
      prev_strobe = strobe;
      mem_resp    = strobe;
    end
    check("starve_grant_count", 32'(grants), 32'd10);
    imem_read = 1'b0;
    dmem_read = 1'b0;
    step();
    mem_resp = 1'b0;
    step();
    step();
    check("starve_end_state", 32'(dut.state), 32'd0);
    check("starve_end_streak", 32'(dut.streak), 32'd0);
    check("starve_end_strobes", 32'({mem_read, mem_write}), 32'd0);

    // Reset while a data write is in flight, then a stray mem_resp.
    idle_inputs();
    dmem_write       = 1'b1;
    dmem_address     = 32'h500;
    dmem_wdata       = 32'h0BADF00D;
    dmem_byte_enable = 4'h5;
    step();
    check("abort_mem_write", 32'(mem_write), 32'd1);
    check("abort_mem_addr", mem_address, 32'h500);
    step();
    rst        = 1'b1;
    dmem_write = 1'b0;
    step();
    check_zero("abort_rst");
    rst       = 1'b0;
    mem_resp  = 1'b1;
    mem_rdata = 32'h77;
    step();
    check_zero("abort_stray");
    mem_resp = 1'b0;
    step();
    check_zero("abort_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the CPU instruction-fetch port (pc/instr/imem_*) and data port (mem_*).
- Sits between the CPU core and the single physical memory/cache port.
- Data requests have priority; a configurable streak limit keeps fetch from starving.
- Every transaction is latched at grant and returned with a registered response.

Parameters:
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending; the next grant then goes to fetch (range 1-15).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- imem_address  input  32  fetch address (pc)
- imem_read  input  1  fetch request, held until imem_resp
- imem_rdata  output  32  fetched instruction
- imem_resp  output  1  one-cycle fetch completion pulse
- dmem_address  input  32  data address
- dmem_read  input  1  data read request, held until dmem_resp
- dmem_write  input  1  data write request, held until dmem_resp
- dmem_wdata  input  32  write data
- dmem_byte_enable  input  4  write byte enables
- dmem_rdata  output  32  read data
- dmem_resp  output  1  one-cycle data completion pulse
- mem_address  output  32  unified port address
- mem_read  output  1  unified read strobe
- mem_write  output  1  unified write strobe
- mem_wdata  output  32  unified write data
- mem_byte_enable  output  4  unified byte enables
- mem_rdata  input  32  unified read data
- mem_resp  input  1  unified completion, valid one cycle

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state = IDLE, streak = 0.
  - All outputs 0: mem_*, imem_rdata/imem_resp, dmem_rdata/dmem_resp.
- Reset mid-transaction: the in-flight access is abandoned, and a later mem_resp is ignored in IDLE.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, grant decision at the clock edge:
  - d_req = dmem_read | dmem_write; i_req = imem_read.
  - d_req and (!i_req or streak < MAX_D_STREAK): go to BUSY_D. If i_req, streak++ (saturating at 15); otherwise streak = 0.
  - Else if i_req: go to BUSY_I, streak = 0.
  - Else stay in IDLE.
- Latch at grant:
  - Latch address, wdata, byte_enable and operation.
  - Fetch: mem_read = 1, mem_byte_enable = 4'hF.
  - Data:
    - dmem_write wins if both dmem_read and dmem_write are high.
    - Write: mem_write = 1, mem_byte_enable = dmem_byte_enable.
    - Read: mem_read = 1, mem_byte_enable = 4'hF.
  - Registered mem_* outputs are valid from the cycle after grant and stay stable until mem_resp.
  - mem_* outputs do not track requester changes after grant.
- BUSY_x: hold outputs until mem_resp = 1. On mem_resp at the edge:
  - Capture mem_rdata into x_rdata.
  - Deassert mem_read/mem_write.
  - Go to RESP_x.
- RESP_x:
  - Assert x_resp for exactly one cycle; x_rdata is valid in that cycle and holds until the next capture.
  - Next state is IDLE; no grant is made in RESP.
  - This guarantees the requester drops or changes its request before re-arbitration, so there are no duplicate accesses.
- Latency, request to resp:
  - 2 cycles + memory latency. Request seen in IDLE at cycle t; mem_* asserted from t+1.
  - mem_resp at cycle t+k gives x_resp at t+k+1, and the arbiter is back in IDLE at t+k+2.
- The non-granted requester simply waits. Its request must stay asserted; no queueing beyond the request lines.
- mem_resp outside BUSY_x is ignored.
- Requester deasserting its request while granted is illegal; the access still completes.

Test Plan:
- Reset, then fetch-only: imem_read=1, addr 0x60, mem_resp with 0x00000013 after 3 cycles.
  - mem_read=1, mem_address=0x60, mem_byte_enable=F from cycle 1.
  - imem_resp is a single pulse with imem_rdata=0x00000013.
  - Total latency is 5 cycles.
- Simultaneous fetch 0x64 and data write 0x100, wdata 0xDEADBEEF, be 4'b0011:
  - The data write is granted first, with mem_write=1, mem_byte_enable=3 and mem_wdata=DEADBEEF.
  - Fetch is then granted with mem_read=1 after dmem_resp plus one IDLE-return cycle.
- Starvation with MAX_D_STREAK=4: continuous data reads plus a pending fetch -> exactly 4 data grants, then 1 fetch grant, then streak resets.
- dmem_read and dmem_write both 1 -> only mem_write is asserted; mem_read stays 0.
- rst during BUSY_D, then mem_resp arrives one cycle later:
  - All outputs are 0 and the state is IDLE.
  - No dmem_resp is produced; the stray mem_resp is ignored.
- mem_resp pulsed while IDLE with no requests -> no x_resp; rdata registers unchanged.
